// File: rtl/sram_test_pkg.sv
// Shared types and helpers for the SRAM compare/scrub block.
// Holds the sequencer state enum, record-field offsets and saturation helpers.
package sram_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SCAN,
        REWRITE
    } state_t;

    localparam int STAMP_W = 16;

    // Record layout, LSB first: data_q, data_exp, addr (then optional stamp).
    function automatic int q_lsb();
        return 0;
    endfunction

    function automatic int exp_lsb(input int dw);
        return dw;
    endfunction

    function automatic int addr_lsb(input int dw);
        return 2 * dw;
    endfunction

    function automatic int rec_w(input int dw, input int aw);
        return aw + 2 * dw;
    endfunction

    function automatic logic [STAMP_W-1:0] sat_inc16(
        input logic [STAMP_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    // A push is lost only when the FIFO is full and nothing leaves it.
    function automatic logic dropped(
        input logic push,
        input logic full,
        input logic pop
    );
        return push & full & ~pop;
    endfunction

endpackage

// File: rtl/sram_err_fifo.sv
// Synchronous error-record FIFO with flush.
// Ports: CLK, reset (sync, active-low), push/din, pop/dout, flush, full, empty.
module sram_err_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty & ~flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop) & ~flush;
    assign dout    = mem[rp];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            cnt <= cnt + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/sram_cmpr_scrub.sv
// SRAM fill / compare / scrub sequencer with error log and serial readout.
// Ports: CLK, reset (sync, active-low), start, clear_error (active-low),
//   addr_start/addr_end, data_exp/data_q, sram_addr/rdwen, error,
//   err_overflow, err_count, shift_load/shift_en, ser_out.
// Option SRAM_CMPR_PASS_STAMP_EN: adds pass_count and stamps it on records.
module sram_cmpr_scrub
    import sram_test_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 15,
    parameter int ERR_DEPTH    = 4,
    parameter int REWRITE_SPAN = 2,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_error,
    input  logic [ADDR_W-1:0] addr_start,
    input  logic [ADDR_W-1:0] addr_end,
    input  logic [DATA_W-1:0] data_exp,
    input  logic [DATA_W-1:0] data_q,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              rdwen,
    output logic              error,
    output logic              err_overflow,
    output logic [CNT_W-1:0]  err_count,
`ifdef SRAM_CMPR_PASS_STAMP_EN
    output logic [STAMP_W-1:0] pass_count,
`endif
    input  logic              shift_load,
    input  logic              shift_en,
    output logic              ser_out
);
    localparam int Q_LSB  = q_lsb();
    localparam int E_LSB  = exp_lsb(DATA_W);
    localparam int A_LSB  = addr_lsb(DATA_W);
    localparam int BASE_W = rec_w(DATA_W, ADDR_W);
`ifdef SRAM_CMPR_PASS_STAMP_EN
    localparam int REC_W  = BASE_W + STAMP_W;
`else
    localparam int REC_W  = BASE_W;
`endif

    state_t            state;
    logic [ADDR_W-1:0] fail_addr;
    logic [ADDR_W-1:0] nxt_addr;
    logic [ADDR_W-1:0] rw_start;
    logic [ADDR_W:0]   lo_lim;
    logic              at_end;
    logic              mismatch;
    logic [REC_W-1:0]  rec;
    logic [REC_W-1:0]  head;
    logic [REC_W-1:0]  shreg;
    logic              fifo_full;
    logic              fifo_empty;

    assign at_end   = (sram_addr == addr_end);
    assign nxt_addr = at_end ? addr_start : sram_addr + 1'b1;
    assign mismatch = (state == SCAN) && (data_q != data_exp);

    // Rewrite start is max(A - SPAN, addr_start), computed one bit wider
    // so a small A cannot wrap below zero.
    assign lo_lim   = {1'b0, addr_start} + (ADDR_W+1)'(REWRITE_SPAN);
    assign rw_start = ({1'b0, sram_addr} < lo_lim)
                    ? addr_start
                    : sram_addr - ADDR_W'(REWRITE_SPAN);

    always_comb begin
        rec = '0;
        rec[Q_LSB +: DATA_W] = data_q;
        rec[E_LSB +: DATA_W] = data_exp;
        rec[A_LSB +: ADDR_W] = sram_addr;
`ifdef SRAM_CMPR_PASS_STAMP_EN
        rec[BASE_W +: STAMP_W] = pass_count;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state     <= IDLE;
            sram_addr <= '0;
            rdwen     <= 1'b0;
            fail_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    rdwen <= 1'b0;
                    if (start) begin
                        sram_addr <= addr_start;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (at_end) begin
                        sram_addr <= addr_start;
                        rdwen     <= 1'b1;
                        state     <= SCAN;
                    end else begin
                        sram_addr <= sram_addr + 1'b1;
                    end
                end
                SCAN: begin
                    if (mismatch) begin
                        fail_addr <= sram_addr;
                        sram_addr <= rw_start;
                        rdwen     <= 1'b0;
                        state     <= REWRITE;
                    end else begin
                        sram_addr <= nxt_addr;
                    end
                end
                REWRITE: begin
                    // On the failing address nxt_addr already holds the
                    // wrapped fail_addr + 1.
                    if (sram_addr == fail_addr) begin
                        sram_addr <= nxt_addr;
                        rdwen     <= 1'b1;
                        state     <= SCAN;
                    end else begin
                        sram_addr <= sram_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset || !clear_error) begin
            err_count    <= '0;
            err_overflow <= 1'b0;
`ifdef SRAM_CMPR_PASS_STAMP_EN
            pass_count   <= '0;
`endif
        end else begin
            if (mismatch && !(&err_count)) begin
                err_count <= err_count + 1'b1;
            end
            if (dropped(mismatch, fifo_full, shift_load)) begin
                err_overflow <= 1'b1;
            end
`ifdef SRAM_CMPR_PASS_STAMP_EN
            if (state == SCAN && !mismatch && at_end) begin
                pass_count <= sat_inc16(pass_count);
            end
`endif
        end
    end

    sram_err_fifo #(
        .WIDTH (REC_W),
        .DEPTH (ERR_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (mismatch),
        .pop   (shift_load),
        .flush (~clear_error),
        .din   (rec),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign error = ~fifo_empty;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            shreg   <= '0;
            ser_out <= 1'b0;
        end else if (shift_load) begin
            shreg <= (fifo_empty || !clear_error) ? '0 : head;
        end else if (shift_en) begin
            ser_out <= shreg[0];
            shreg   <= shreg >> 1;
        end
    end

endmodule

// File: tb/tb_sram_cmpr_scrub.sv
// Self-checking bench for sram_cmpr_scrub (default build).
// Scoreboards: expected bus cycles and expected error records.
module tb_sram_cmpr_scrub;
    localparam int AW    = 15;
    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 4;
    localparam int RW    = AW + 2 * DW;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          clear_error = 1'b1;
    logic [AW-1:0] addr_start = 15'd10;
    logic [AW-1:0] addr_end = 15'd13;
    logic [DW-1:0] data_exp;
    logic [DW-1:0] data_q;
    logic [AW-1:0] sram_addr;
    logic          rdwen;
    logic          error;
    logic          err_overflow;
    logic [CW-1:0] err_count;
    logic          shift_load = 1'b0;
    logic          shift_en = 1'b0;
    logic          ser_out;

    logic          inj_arm = 1'b0;
    logic [AW-1:0] inj_addr = '0;
    logic [DW-1:0] inj_val = '0;
    logic          hit_seen = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int fifo_n = 0;
    int exp_cnt = 0;
    logic exp_ovf = 1'b0;

    logic [AW:0]   bus_q[$];
    logic [RW-1:0] rec_q[$];

    sram_cmpr_scrub dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .clear_error  (clear_error),
        .addr_start   (addr_start),
        .addr_end     (addr_end),
        .data_exp     (data_exp),
        .data_q       (data_q),
        .sram_addr    (sram_addr),
        .rdwen        (rdwen),
        .error        (error),
        .err_overflow (err_overflow),
        .err_count    (err_count),
        .shift_load   (shift_load),
        .shift_en     (shift_en),
        .ser_out      (ser_out)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA9;
    endfunction

    assign data_exp = pat(sram_addr);
    assign data_q = (inj_arm && rdwen && sram_addr == inj_addr)
                  ? inj_val : data_exp;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        logic hit;
        hit = inj_arm && rdwen && (sram_addr == inj_addr);
        @(posedge CLK);
        #1;
        if (hit) begin
            inj_arm  = 1'b0;
            hit_seen = 1'b1;
            if (exp_cnt < 65535) exp_cnt++;
            if (fifo_n < DEPTH) begin
                rec_q.push_back({inj_addr, pat(inj_addr), inj_val});
                fifo_n++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic push_bus(input logic [AW-1:0] a, input logic rw);
        bus_q.push_back({a, rw});
    endtask

    task automatic run_bus();
        logic [AW:0] e;
        while (bus_q.size() > 0) begin
            e = bus_q.pop_front();
            check("bus", {48'd0, sram_addr, rdwen}, {48'd0, e});
            cyc();
        end
    endtask

    task automatic inject(input logic [AW-1:0] a, input logic [DW-1:0] v);
        inj_addr = a;
        inj_val  = v;
        inj_arm  = 1'b1;
        hit_seen = 1'b0;
        for (int i = 0; i < 64 && !hit_seen; i++) cyc();
        check("inj_hit", {63'd0, hit_seen}, 64'd1);
    endtask

    task automatic shift_rec();
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        exp = '0;
        if (fifo_n > 0) begin
            exp = rec_q.pop_front();
            fifo_n--;
        end
        shift_load = 1'b1;
        cyc();
        shift_load = 1'b0;
        shift_en = 1'b1;
        for (int i = 0; i < RW; i++) begin
            cyc();
            got[i] = ser_out;
        end
        shift_en = 1'b0;
        check("ser_rec", {33'd0, got}, {33'd0, exp});
    endtask

    task automatic check_cnt();
        check("err_count", {48'd0, err_count}, 64'(exp_cnt));
        check("error", {63'd0, error}, {63'd0, fifo_n > 0});
        check("err_ovf", {63'd0, err_overflow}, {63'd0, exp_ovf});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a;

        cyc();
        cyc();
        check("rst_addr", {49'd0, sram_addr}, 64'd0);
        check("rst_rdwen", {63'd0, rdwen}, 64'd0);
        check("rst_ser", {63'd0, ser_out}, 64'd0);
        check_cnt();
        reset = 1'b1;
        cyc();

        // Fill then scan over 10..13
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 10; i <= 13; i++) push_bus(AW'(i), 1'b0);
        for (int i = 10; i <= 13; i++) push_bus(AW'(i), 1'b1);
        push_bus(15'd10, 1'b1);
        run_bus();
        check_cnt();

        // start outside IDLE has no effect
        a = sram_addr;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_ign", {48'd0, sram_addr, rdwen},
              {48'd0, (a == addr_end) ? addr_start : a + 1'b1, 1'b1});

        // Mismatch at 12: rewrite 10..12, resume at 13
        inject(15'd12, 8'h5A);
        push_bus(15'd10, 1'b0);
        push_bus(15'd11, 1'b0);
        push_bus(15'd12, 1'b0);
        push_bus(15'd13, 1'b1);
        push_bus(15'd10, 1'b1);
        run_bus();
        check_cnt();

        // Serial readout of that record
        shift_rec();
        check_cnt();

        // Mismatch at addr_start: rewrite clamped to a single address
        inject(15'd10, 8'h00);
        push_bus(15'd10, 1'b0);
        push_bus(15'd11, 1'b1);
        push_bus(15'd12, 1'b1);
        run_bus();
        check_cnt();

        // clear_error flushes the log without disturbing the scan
        a = sram_addr;
        clear_error = 1'b0;
        cyc();
        clear_error = 1'b1;
        rec_q.delete();
        fifo_n = 0;
        exp_cnt = 0;
        exp_ovf = 1'b0;
        check_cnt();
        check("clr_scan", {48'd0, sram_addr, rdwen},
              {48'd0, (a == addr_end) ? addr_start : a + 1'b1, 1'b1});

        // Five mismatches against a four-deep log
        inject(15'd11, 8'h11);
        inject(15'd13, 8'h22);
        inject(15'd10, 8'h33);
        inject(15'd12, 8'h44);
        inject(15'd11, 8'h55);
        check_cnt();
        for (int i = 0; i < DEPTH; i++) shift_rec();
        check_cnt();
        shift_rec();

        // Reset in the middle of a rewrite
        inject(15'd13, 8'hFF);
        check("in_rewrite", {63'd0, rdwen}, 64'd0);
        reset = 1'b0;
        cyc();
        rec_q.delete();
        fifo_n = 0;
        exp_cnt = 0;
        exp_ovf = 1'b0;
        check("rst2_addr", {49'd0, sram_addr}, 64'd0);
        check("rst2_rdwen", {63'd0, rdwen}, 64'd0);
        check("rst2_ser", {63'd0, ser_out}, 64'd0);
        check_cnt();
        reset = 1'b1;
        cyc();
        check("idle_hold", {48'd0, sram_addr, rdwen}, 64'd0);

        // Degenerate single-address range
        addr_start = 15'd20;
        addr_end = 15'd20;
        start = 1'b1;
        cyc();
        start = 1'b0;
        push_bus(15'd20, 1'b0);
        push_bus(15'd20, 1'b1);
        push_bus(15'd20, 1'b1);
        run_bus();
        inject(15'd20, 8'h00);
        push_bus(15'd20, 1'b0);
        push_bus(15'd20, 1'b1);
        push_bus(15'd20, 1'b1);
        run_bus();
        check_cnt();
        shift_rec();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
